// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller slice.
// Contents:
//   state_t     - controller state encoding (3 bits)
//   COIN_*      - coin acceptor codes
//   coin_value  - unit value of a coin code (0 for none/invalid)
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    REFUND = 3'd4
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  function automatic logic [1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_ONE: coin_value = 2'd1;
      COIN_TWO: coin_value = 2'd2;
      default:  coin_value = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_payout.sv
// Payout engine shared by change and refund: a down-counter that emits one
// chg_pulse per unit, each pulse followed by one gap cycle.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   load        - start a payout of load_val units (first pulse next cycle)
//   load_val    - number of units to pay
//   chg_pulse   - registered one-cycle pulse per unit
//   done        - gap cycle with nothing left to pay (also high when idle)
//   count       - units still owed after the pulse currently shown
module vend_payout #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         chg_pulse,
  output logic         done,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic         pulse_q;

  // The first pulse is issued straight from the load so the pattern starts
  // on the first cycle of CHANGE/REFUND; after that pulses alternate with gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (load) begin
      if (load_val != '0) begin
        cnt_q   <= load_val - W'(1);
        pulse_q <= 1'b1;
      end else begin
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end
    end else if (pulse_q) begin
      pulse_q <= 1'b0;
    end else if (cnt_q != '0) begin
      cnt_q   <= cnt_q - W'(1);
      pulse_q <= 1'b1;
    end
  end

  assign chg_pulse = pulse_q;
  assign done      = !pulse_q && (cnt_q == '0);
  assign count     = cnt_q;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencing controller: accumulates coin credit against PRICE,
// runs the dispense request/acknowledge handshake, then pays out change;
// refunds credit on cancel or inactivity timeout.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   coin         - per-cycle coin code (00 none, 01 one, 10 two, 11 invalid)
//   cancel       - user cancel (honoured in CREDIT only)
//   disp_ack     - dispense mechanism done (honoured in VEND only)
//   disp_req     - registered dispense request
//   chg_pulse    - registered pulse per returned unit
//   coin_reject  - pulse: previous cycle's coin was not accepted
//   credit       - credit in IDLE/CREDIT, units still owed in CHANGE/REFUND
//   busy         - registered, high in VEND/CHANGE/REFUND
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE       = 3,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TMR_W       = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                chg_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] chg_q, chg_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                reject_d;
  logic                disp_req_q, busy_q, reject_q;
  logic                pay_load, pay_done;
  logic [CREDIT_W-1:0] pay_val, pay_count;
  logic [CREDIT_W-1:0] value, sum;

  assign value = CREDIT_W'(coin_value(coin));
  assign sum   = credit_q + value;

  // Next-state logic. In CREDIT, cancel beats a coin, and an accepted coin
  // beats the timeout since it restarts the idle period.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    chg_d    = chg_q;
    timer_d  = timer_q;
    reject_d = (coin == COIN_BAD);
    pay_load = 1'b0;
    pay_val  = '0;
    case (state_q)
      IDLE, CREDIT: begin
        if (state_q == CREDIT && cancel) begin
          reject_d = (coin != COIN_NONE);
          state_d  = REFUND;
          pay_load = 1'b1;
          pay_val  = credit_q;
          credit_d = '0;
          timer_d  = '0;
        end else if (value != '0) begin
          timer_d = '0;
          if (sum >= CREDIT_W'(PRICE)) begin
            state_d  = VEND;
            chg_d    = sum - CREDIT_W'(PRICE);
            credit_d = '0;
          end else begin
            state_d  = CREDIT;
            credit_d = sum;
          end
        end else if (state_q == CREDIT) begin
          if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_d  = REFUND;
            pay_load = 1'b1;
            pay_val  = credit_q;
            credit_d = '0;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      VEND: begin
        reject_d = (coin != COIN_NONE);
        if (disp_ack) begin
          chg_d = '0;
          if (chg_q != '0) begin
            state_d  = CHANGE;
            pay_load = 1'b1;
            pay_val  = chg_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE, REFUND: begin
        reject_d = (coin != COIN_NONE);
        if (pay_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      chg_q      <= '0;
      timer_q    <= '0;
      disp_req_q <= 1'b0;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      chg_q      <= chg_d;
      timer_q    <= timer_d;
      disp_req_q <= (state_d == VEND);
      busy_q     <= (state_d == VEND) || (state_d == CHANGE) || (state_d == REFUND);
      reject_q   <= reject_d;
    end
  end

  vend_payout #(.W(CREDIT_W)) u_payout (
    .clk       (clk),
    .rst       (rst),
    .load      (pay_load),
    .load_val  (pay_val),
    .chg_pulse (chg_pulse),
    .done      (pay_done),
    .count     (pay_count)
  );

  assign disp_req    = disp_req_q;
  assign busy        = busy_q;
  assign coin_reject = reject_q;
  assign credit      = (state_q == CHANGE || state_q == REFUND) ? pay_count : credit_q;

endmodule
